// File: rtl/ram8_ctrl_pkg.sv
// ram8_ctrl_pkg
// Shared definitions for the ram8 bank controller: controller state
// encoding, bank word width and the fill-value selector constants.
package ram8_ctrl_pkg;

  localparam int unsigned WORD_W = 8;

  // Fill value selector, as sampled from fill_ones.
  localparam logic FILL_CLEAR  = 1'b0;
  localparam logic FILL_PRESET = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    FILL
  } ctrl_state_e;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Two-way round-robin picker. Purely combinational; the pointer of the
// last granted requester is held by the instantiating controller.
// Ports:
//   req  [1:0] in  request vector, bit i = requester i
//   last       in  requester granted most recently (0 or 1)
//   pick [1:0] out one-hot winner, all zero when nobody requests
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);

  always_comb begin
    pick = '0;
    unique case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      // Tie: the requester that did not win last time goes now.
      2'b11:   pick = last ? 2'b01 : 2'b10;
      default: pick = '0;
    endcase
  end

endmodule

// File: rtl/ram8_bank_ctrl.sv
// ram8_bank_ctrl
// Shares a bank of WORDS 8-bit words between two requesters and sequences
// bulk clear/preset fills. Owns every write enable, clear and preset strobe
// of the bank. Word accesses are arbitrated round-robin; a fill has
// priority in IDLE and walks the bank one word per cycle.
// Ports:
//   clk                 in  clock, rising edge
//   clear               in  asynchronous active-low reset
//   req0/1, we0/1       in  access request (level) and write flag
//   addr0/1, wdata0/1   in  target word and write data
//   gnt0/1              out one-cycle grant pulse (request consumed)
//   rvalid0/1           out one-cycle read-data-valid pulse
//   rdata               out shared read data, held between reads
//   fill_req, fill_ones in  bulk fill request and fill value (1 = 0xFF)
//   fill_busy           out high during the whole fill
//   mem_we              out one-hot bank write enable
//   mem_clear/preset    out one-hot per-word clear / preset strobes
//   mem_din             out bank write data (0 outside write cycles)
//   mem_dout            in  bank read data, word k at [8k+7:8k]
module ram8_bank_ctrl
  import ram8_ctrl_pkg::*;
#(
  parameter  int unsigned WORDS = 4,
  localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic                      req0,
  input  logic                      we0,
  input  logic [AW-1:0]             addr0,
  input  logic [WORD_W-1:0]         wdata0,
  input  logic                      req1,
  input  logic                      we1,
  input  logic [AW-1:0]             addr1,
  input  logic [WORD_W-1:0]         wdata1,
  output logic                      gnt0,
  output logic                      gnt1,
  output logic                      rvalid0,
  output logic                      rvalid1,
  output logic [WORD_W-1:0]         rdata,
  input  logic                      fill_req,
  input  logic                      fill_ones,
  output logic                      fill_busy,
  output logic [WORDS-1:0]          mem_we,
  output logic [WORDS-1:0]          mem_clear,
  output logic [WORDS-1:0]          mem_preset,
  output logic [WORD_W-1:0]         mem_din,
  input  logic [WORD_W*WORDS-1:0]   mem_dout
);

  ctrl_state_e       state_q, state_d;
  logic              last_q, last_d;       // last granted requester
  logic              win_q, win_d;         // current winner (0/1)
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              fill_ones_q, fill_ones_d;
  logic [AW-1:0]     cnt_q, cnt_d;         // fill word counter
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic [1:0]        pick;
  logic [WORD_W-1:0] rd_word;
  logic [WORDS-1:0]  addr_onehot;
  logic [WORDS-1:0]  cnt_onehot;

  rr_arb2 u_arb (
    .req  ({req1, req0}),
    .last (last_q),
    .pick (pick)
  );

  // Bank word selected by the captured address.
  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (addr_q == AW'(k)) begin
        rd_word = mem_dout[k*WORD_W +: WORD_W];
      end
    end
  end

  assign addr_onehot = WORDS'(1) << addr_q;
  assign cnt_onehot  = WORDS'(1) << cnt_q;

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fill_ones_d = fill_ones_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (fill_req) begin
          state_d     = FILL;
          fill_ones_d = fill_ones;
          cnt_d       = '0;
        end else if (|pick) begin
          state_d = ACCESS;
          win_d   = pick[1];
          last_d  = pick[1];
          we_d    = pick[1] ? we1    : we0;
          addr_d  = pick[1] ? addr1  : addr0;
          wdata_d = pick[1] ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
        end else begin
          rdata_d = rd_word;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      FILL: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == AW'(WORDS - 1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode only registered state, so the asynchronous reset
  // removes every strobe in the same cycle it is asserted.
  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rvalid0    = 1'b0;
    rvalid1    = 1'b0;
    fill_busy  = 1'b0;
    mem_we     = '0;
    mem_clear  = '0;
    mem_preset = '0;
    mem_din    = '0;

    unique case (state_q)
      ACCESS: begin
        gnt0 = ~win_q;
        gnt1 =  win_q;
        if (we_q) begin
          mem_we  = addr_onehot;
          mem_din = wdata_q;
        end
      end
      RESP: begin
        rvalid0 = ~win_q;
        rvalid1 =  win_q;
      end
      FILL: begin
        fill_busy = 1'b1;
        if (fill_ones_q == FILL_PRESET) begin
          mem_preset = cnt_onehot;
        end else begin
          mem_clear  = cnt_onehot;
        end
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fill_ones_q <= FILL_CLEAR;
      cnt_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fill_ones_q <= fill_ones_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
    end
  end

endmodule

// File: tb/tb_ram8_bank_ctrl.sv
// tb_ram8_bank_ctrl
// Directed bench for ram8_bank_ctrl with a behavioural 4-word bank,
// followed by a stretch of random traffic watched by a protocol monitor.
module tb_ram8_bank_ctrl;

  localparam int unsigned WORDS = 4;
  localparam int unsigned AW    = 2;

  logic              clk = 1'b0;
  logic              clear;
  logic              req0, we0, req1, we1;
  logic [AW-1:0]     addr0, addr1;
  logic [7:0]        wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]        rdata;
  logic              fill_req, fill_ones, fill_busy;
  logic [WORDS-1:0]  mem_we, mem_clear, mem_preset;
  logic [7:0]        mem_din;
  logic [8*WORDS-1:0] mem_dout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram8_bank_ctrl #(.WORDS(WORDS)) dut (
    .clk        (clk),
    .clear      (clear),
    .req0       (req0),
    .we0        (we0),
    .addr0      (addr0),
    .wdata0     (wdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata),
    .fill_req   (fill_req),
    .fill_ones  (fill_ones),
    .fill_busy  (fill_busy),
    .mem_we     (mem_we),
    .mem_clear  (mem_clear),
    .mem_preset (mem_preset),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  // Behavioural bank: WORDS x ram1x8, no reset of its own.
  logic [7:0] bank [WORDS];
  initial for (int k = 0; k < WORDS; k++) bank[k] = 8'h00;
  always @(posedge clk) begin
    for (int k = 0; k < WORDS; k++) begin
      if (mem_clear[k])       bank[k] <= 8'h00;
      else if (mem_preset[k]) bank[k] <= 8'hFF;
      else if (mem_we[k])     bank[k] <= mem_din;
    end
  end
  assign mem_dout = {bank[3], bank[2], bank[1], bank[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One access through the given port from IDLE; gnt is due in the first
  // cycle after the sampling edge.
  task automatic do_access(input bit port, input bit we, input logic [1:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
    logic [3:0] exp_we;
    exp_we = we ? (4'b0001 << addr) : 4'b0000;
    @(posedge clk); #1;
    if (!port) begin req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wd; end
    else       begin req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wd; end
    @(posedge clk);
    @(negedge clk);
    check("acc_gnt",       port ? gnt1 : gnt0, 1);
    check("acc_gnt_other", port ? gnt0 : gnt1, 0);
    check("acc_mem_we",    mem_we, exp_we);
    check("acc_mem_din",   mem_din, we ? wd : 8'h00);
    @(posedge clk); #1;
    if (!port) req0 = 1'b0; else req1 = 1'b0;
    @(negedge clk);
    if (!we) begin
      check("acc_rvalid", port ? rvalid1 : rvalid0, 1);
      check("acc_rdata",  rdata, exp_rd);
    end else begin
      check("acc_we_off", mem_we, 0);
      check("acc_bank",   bank[addr], wd);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"},    {gnt1, gnt0}, 0);
    check({tag, "_rvalid"}, {rvalid1, rvalid0}, 0);
    check({tag, "_busy"},   fill_busy, 0);
    check({tag, "_strobe"}, {mem_we, mem_clear, mem_preset}, 0);
    check({tag, "_din"},    mem_din, 0);
  endtask

  // Protocol monitor used during random traffic.
  bit         mon_en = 1'b0;
  bit         prev_rg0, prev_rg1;
  logic [7:0] exp_rd0, exp_rd1;
  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_strobe_excl", ($countones({mem_we, mem_clear, mem_preset}) <= 1), 1);
      check("mon_gnt_excl", gnt0 & gnt1, 0);
      check("mon_rvalid0", rvalid0, prev_rg0);
      check("mon_rvalid1", rvalid1, prev_rg1);
      if (rvalid0) check("mon_rdata0", rdata, exp_rd0);
      if (rvalid1) check("mon_rdata1", rdata, exp_rd1);
      if (mem_we == 0) check("mon_din_zero", mem_din, 0);
      prev_rg0 = gnt0 && !we0;
      prev_rg1 = gnt1 && !we1;
      if (prev_rg0) exp_rd0 = bank[addr0];
      if (prev_rg1) exp_rd1 = bank[addr1];
    end else begin
      prev_rg0 = 1'b0;
      prev_rg1 = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [1:0] tie_exp [7] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

  initial begin
    bit g0, g1, fb;
    clear = 1'b0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
    fill_req = 0; fill_ones = 0;

    // Reset state.
    repeat (2) @(negedge clk);
    check_quiet("rst");
    check("rst_rdata", rdata, 8'h00);
    clear = 1'b1;

    // Single write then read.
    do_access(1'b0, 1'b1, 2'd2, 8'hA5, 8'h00);
    do_access(1'b0, 1'b0, 2'd2, 8'h00, 8'hA5);
    @(negedge clk);
    check("rdata_hold_rvalid", rvalid0, 0);
    check("rdata_hold", rdata, 8'hA5);
    do_access(1'b1, 1'b1, 2'd1, 8'h5C, 8'h00);
    do_access(1'b1, 1'b0, 2'd1, 8'h00, 8'h5C);

    // Reset restores the pointer so requester 0 wins the first tie.
    @(negedge clk); clear = 1'b0;
    #1 check("rst2_rdata", rdata, 8'h00);
    @(negedge clk); clear = 1'b1;

    // Tie arbitration with both requests held.
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 2'd0; wdata0 = 8'h11;
    req1 = 1; we1 = 1; addr1 = 2'd1; wdata1 = 8'h22;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (i == 6) begin req0 = 0; req1 = 0; end
      @(negedge clk);
      check("tie_gnt", {gnt1, gnt0}, tie_exp[i]);
    end
    @(negedge clk);
    check("tie_bank0", bank[0], 8'h11);
    check("tie_bank1", bank[1], 8'h22);

    // Preset fill.
    @(posedge clk); #1;
    fill_req = 1; fill_ones = 1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      fill_req = 0;
      @(negedge clk);
      check("pre_busy",   fill_busy, 1);
      check("pre_preset", mem_preset, 4'b0001 << k);
      check("pre_clear",  mem_clear, 0);
      check("pre_we",     mem_we, 0);
    end
    @(negedge clk);
    check("pre_done", fill_busy, 0);
    for (int k = 0; k < 4; k++) check("pre_bank", bank[k], 8'hFF);
    do_access(1'b1, 1'b0, 2'd1, 8'h00, 8'hFF);

    // Clear fill with a simultaneous write request: fill goes first.
    @(posedge clk); #1;
    fill_req = 1; fill_ones = 0;
    req1 = 1; we1 = 1; addr1 = 2'd3; wdata1 = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      fill_req = 0;
      @(negedge clk);
      check("clr_busy",  fill_busy, 1);
      check("clr_clear", mem_clear, 4'b0001 << k);
      check("clr_gnt1",  gnt1, 0);
    end
    @(negedge clk);
    check("clr_idle_busy", fill_busy, 0);
    check("clr_idle_gnt1", gnt1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("prio_gnt1",   gnt1, 1);
    check("prio_mem_we", mem_we, 4'b1000);
    check("prio_din",    mem_din, 8'h3C);
    @(posedge clk); #1;
    req1 = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) check("clr_bank", bank[k], 8'h00);
    check("prio_bank3", bank[3], 8'h3C);
    do_access(1'b0, 1'b0, 2'd3, 8'h00, 8'h3C);

    // Reset in fill cycle 1: strobes drop at once, partial fill kept.
    @(posedge clk); #1;
    fill_req = 1; fill_ones = 1;
    @(posedge clk); #1;
    fill_req = 0;
    @(negedge clk);
    check("mid_preset0", mem_preset, 4'b0001);
    @(negedge clk);
    check("mid_preset1", mem_preset, 4'b0010);
    #1 clear = 1'b0;
    #1;
    check_quiet("mid_rst");
    check("mid_rst_rdata", rdata, 8'h00);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    check_quiet("mid_after");
    check("mid_bank0", bank[0], 8'hFF);
    check("mid_bank1", bank[1], 8'h00);
    check("mid_bank2", bank[2], 8'h00);
    check("mid_bank3", bank[3], 8'h3C);
    do_access(1'b1, 1'b1, 2'd2, 8'h5A, 8'h00);

    // Random traffic under the monitor.
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1; fb = fill_busy;
      @(posedge clk); #1;
      if (g0) req0 = 0;
      else if (!req0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; we0 = $urandom_range(0, 1); addr0 = 2'($urandom_range(0, 3));
        wdata0 = 8'($urandom_range(0, 255));
      end
      if (g1) req1 = 0;
      else if (!req1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; we1 = $urandom_range(0, 1); addr1 = 2'($urandom_range(0, 3));
        wdata1 = 8'($urandom_range(0, 255));
      end
      if (fb) fill_req = 0;
      else if (!fill_req && $urandom_range(0, 49) == 0) begin
        fill_req = 1; fill_ones = $urandom_range(0, 1);
      end
    end
    req0 = 0; req1 = 0; fill_req = 0;
    repeat (10) @(negedge clk);
    mon_en = 1'b0;
    check_quiet("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
